// File: rtl/kbd_iot_device_pkg.sv
// ---------------------------------------------------------------------------
// kbd_iot_device_pkg
//   Shared definitions for IOT-group peripherals (603x-style responders).
//   - Device code of the console keyboard.
//   - IOT function codes (instruction bits 9-11) as a typed enum.
//   - Sequencer phase-pulse bundle. The CPU IOT sequencer issues, for every
//     IOT, three single-cycle pulses in the order ck1 -> stb1 -> ck2. A
//     device ends the instruction by raising done on one of those phases.
//   - Helper that formats an 8-bit device byte for the 12-bit AC bus.
// ---------------------------------------------------------------------------
package kbd_iot_device_pkg;

    localparam logic [5:0] KBD_DEV_CODE = 6'o03;
    localparam int         AC_W         = 12;
    localparam int         KBD_DATA_W   = 8;

    // IOT function codes for the keyboard; 3 and 7 are reserved.
    typedef enum logic [2:0] {
        IOT_KCF  = 3'd0,
        IOT_KSF  = 3'd1,
        IOT_KCC  = 3'd2,
        IOT_RSV3 = 3'd3,
        IOT_KRS  = 3'd4,
        IOT_KIE  = 3'd5,
        IOT_KRB  = 3'd6,
        IOT_RSV7 = 3'd7
    } kbd_fn_e;

    // Sequencer phases, one cycle each, always in this order.
    typedef struct packed {
        logic ck1;
        logic stb1;
        logic ck2;
    } iot_phase_t;

    // Zero-extends a device byte onto the AC data bus.
    function automatic logic [AC_W-1:0] byte_to_ac(input logic [KBD_DATA_W-1:0] b);
        return {4'b0000, b};
    endfunction

endpackage

// File: rtl/kbd_iot_device_sync_fifo.sv
// ---------------------------------------------------------------------------
// kbd_iot_device_sync_fifo
//   Single-clock FIFO with synchronous active-high clear.
//   Ports:
//     clk_i, clear_i   clock / synchronous clear (priority over push/pop)
//     push_i, data_i   write request and data (ignored while full)
//     pop_i            read request (ignored while empty)
//     data_o           current head entry (valid when !empty_o)
//     full_o, empty_o  status
//     count_o          number of stored entries, 0..DEPTH
//   DEPTH must be a power of two (>= 2) so pointers wrap naturally.
// ---------------------------------------------------------------------------
module kbd_iot_device_sync_fifo #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 2,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk_i,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  count_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              push_ok_s;
    logic              pop_ok_s;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == {CNT_W{1'b0}});
    assign count_o   = count_q;
    assign data_o    = mem_q[rd_ptr_q];
    assign push_ok_s = push_i & ~full_o;
    assign pop_ok_s  = pop_i & ~empty_o;

    // Next-state for pointers and occupancy count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset because empty_o guards reads.
    always_ff @(posedge clk_i) begin
        if (!clear_i && push_ok_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/kbd_iot_device.sv
// ---------------------------------------------------------------------------
// kbd_iot_device
//   Console keyboard responder (device 03) for the 603x IOT group.
//   Host bytes arrive on a valid/ready stream into a small FIFO; whenever the
//   keyboard flag is clear the FIFO head moves into the buffer register kbb
//   and the flag is set. The CPU reads/clears the flag through IOTs.
//   Ports:
//     CLK, clear             clock / synchronous active-high reset
//     EN, IR[2:0]            device select and IOT function bits
//     ck1, stb1, ck2         sequencer phase pulses (in that order)
//     ac_in[11:0]            current AC (bit 0 used by KIE)
//     done, pc_ck, clr,      combinational sequencer responses, zero
//     dev2ac, ac_ck          whenever EN=0 or clear=1
//     dbus[11:0]             {4'b0, kbb} while dev2ac, else 0
//     irqRq                  registered flag & ie
//     rx_data, rx_valid,     host byte stream; rx_ready = FIFO not full
//     rx_ready
// ---------------------------------------------------------------------------
module kbd_iot_device
    import kbd_iot_device_pkg::*;
#(
    parameter int   DEPTH    = 2,
    parameter logic IE_RESET = 1'b1
) (
    input  logic        CLK,
    input  logic        clear,
    input  logic        EN,
    input  logic [2:0]  IR,
    input  logic        ck1,
    input  logic        ck2,
    input  logic        stb1,
    input  logic [11:0] ac_in,
    output logic        done,
    output logic        pc_ck,
    output logic        clr,
    output logic        dev2ac,
    output logic        ac_ck,
    output logic [11:0] dbus,
    output logic        irqRq,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [7:0]       kbb_q,  kbb_d;
    logic             flag_q, flag_d;
    logic             ie_q,   ie_d;
    logic             irq_q,  irq_d;

    logic [7:0]       fifo_head_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic             push_s;
    logic             load_s;

    kbd_fn_e          fn_s;
    iot_phase_t       ph_s;
    logic             done_s, pc_ck_s, clr_s, dev2ac_s, ac_ck_s;
    logic             flag_clr_s;
    logic             ie_wr_s;
    logic             unused_ac_s;

    assign fn_s        = kbd_fn_e'(IR);
    assign ph_s        = '{ck1: ck1, stb1: stb1, ck2: ck2};
    assign unused_ac_s = ^ac_in[11:1];

    // Host stream: a byte is taken only when the FIFO has room.
    assign push_s   = rx_valid & ~fifo_full_s;
    assign rx_ready = (fifo_count_s != CNT_W'(DEPTH));

    // A flag-clearing strobe in this cycle defers the buffer load by a cycle.
    assign load_s = ~flag_q & ~fifo_empty_s & ~flag_clr_s;

    kbd_iot_device_sync_fifo #(
        .DATA_W (8),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .clear_i (clear),
        .push_i  (push_s),
        .data_i  (rx_data),
        .pop_i   (load_s),
        .data_o  (fifo_head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    // IOT decode: sequencer responses plus flag-clear and ie-write strobes.
    // Suppressed during clear so an interrupted IOT has no further effect.
    always_comb begin
        done_s     = 1'b0;
        pc_ck_s    = 1'b0;
        clr_s      = 1'b0;
        dev2ac_s   = 1'b0;
        ac_ck_s    = 1'b0;
        flag_clr_s = 1'b0;
        ie_wr_s    = 1'b0;
        if (EN && !clear) begin
            case (fn_s)
                IOT_KCF: begin
                    flag_clr_s = ph_s.ck1;
                    done_s     = ph_s.ck1;
                end
                IOT_KSF: begin
                    pc_ck_s = ph_s.stb1 & flag_q;
                    done_s  = ph_s.ck2;
                end
                IOT_KCC: begin
                    clr_s      = ph_s.ck1;
                    ac_ck_s    = ph_s.stb1;
                    flag_clr_s = ph_s.stb1;
                    done_s     = ph_s.ck2;
                end
                IOT_KRS: begin
                    dev2ac_s = ph_s.ck1 | ph_s.stb1;
                    ac_ck_s  = ph_s.stb1;
                    done_s   = ph_s.ck2;
                end
                IOT_KIE: begin
                    ie_wr_s = ph_s.stb1;
                    done_s  = ph_s.ck2;
                end
                IOT_KRB: begin
                    clr_s      = ph_s.ck1;
                    dev2ac_s   = ph_s.ck1 | ph_s.stb1;
                    ac_ck_s    = ph_s.stb1;
                    flag_clr_s = ph_s.stb1;
                    done_s     = ph_s.ck2;
                end
                default: begin
                    // Reserved codes 3 and 7 simply complete on ck1.
                    done_s = ph_s.ck1;
                end
            endcase
        end else begin
            done_s     = 1'b0;
            flag_clr_s = 1'b0;
        end
    end

    assign done   = done_s;
    assign pc_ck  = pc_ck_s;
    assign clr    = clr_s;
    assign dev2ac = dev2ac_s;
    assign ac_ck  = ac_ck_s;
    assign dbus   = dev2ac_s ? byte_to_ac(kbb_q) : 12'h000;
    assign irqRq  = irq_q;

    // Next-state for buffer, flag, interrupt enable and interrupt request.
    always_comb begin
        kbb_d  = kbb_q;
        flag_d = flag_q;
        ie_d   = ie_q;
        irq_d  = flag_q & ie_q;
        if (flag_clr_s) begin
            flag_d = 1'b0;
        end else if (load_s) begin
            flag_d = 1'b1;
            kbb_d  = fifo_head_s;
        end else begin
            flag_d = flag_q;
        end
        if (ie_wr_s) begin
            ie_d = ac_in[0];
        end else begin
            ie_d = ie_q;
        end
    end

    // State registers with synchronous clear.
    always_ff @(posedge CLK) begin
        if (clear) begin
            kbb_q  <= 8'h00;
            flag_q <= 1'b0;
            ie_q   <= IE_RESET;
            irq_q  <= 1'b0;
        end else begin
            kbb_q  <= kbb_d;
            flag_q <= flag_d;
            ie_q   <= ie_d;
            irq_q  <= irq_d;
        end
    end

endmodule

// File: tb/tb_kbd_iot_device.sv
// Directed self-checking bench for kbd_iot_device (DEPTH=2, IE_RESET=1).
module tb_kbd_iot_device;

    logic        CLK = 1'b0;
    logic        clear = 1'b1;
    logic        EN = 1'b0;
    logic [2:0]  IR = 3'd0;
    logic        ck1 = 1'b0, ck2 = 1'b0, stb1 = 1'b0;
    logic [11:0] ac_in = 12'o0000;
    logic        done, pc_ck, clr, dev2ac, ac_ck, irqRq, rx_ready;
    logic [11:0] dbus;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 CLK = ~CLK;

    kbd_iot_device #(.DEPTH(2), .IE_RESET(1'b1)) dut (
        .CLK(CLK), .clear(clear), .EN(EN), .IR(IR), .ck1(ck1), .ck2(ck2),
        .stb1(stb1), .ac_in(ac_in), .done(done), .pc_ck(pc_ck), .clr(clr),
        .dev2ac(dev2ac), .ac_ck(ac_ck), .dbus(dbus), .irqRq(irqRq),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic set_ph(input logic en, input logic [2:0] ir,
                          input logic c1, input logic s1, input logic c2);
        EN = en; IR = ir; ck1 = c1; stb1 = s1; ck2 = c2;
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic run_krb(output logic [11:0] d);
        set_ph(1'b1, 3'd6, 1'b1, 1'b0, 1'b0);
        d = dbus;
        step();
        set_ph(1'b1, 3'd6, 1'b0, 1'b1, 1'b0);
        step();
        set_ph(1'b1, 3'd6, 1'b0, 1'b0, 1'b1);
        step();
        set_ph(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        clear = 1'b1;
        step(); step();
        clear = 1'b0;
        total_cnt++; if (irqRq !== 1'b0) $display("FAIL reset_irq: got %0b want 0", irqRq); else pass_cnt++;
        total_cnt++; if (rx_ready !== 1'b1) $display("FAIL reset_rx_ready: got %0b want 1", rx_ready); else pass_cnt++;
        total_cnt++; if (dut.flag_q !== 1'b0) $display("FAIL reset_flag: got %0b want 0", dut.flag_q); else pass_cnt++;
        total_cnt++; if (dut.kbb_q !== 8'h00) $display("FAIL reset_kbb: got %h want 00", dut.kbb_q); else pass_cnt++;
        total_cnt++; if (dut.ie_q !== 1'b1) $display("FAIL reset_ie: got %0b want 1", dut.ie_q); else pass_cnt++;
        // Phase pulses without EN must produce nothing.
        set_ph(1'b0, 3'd6, 1'b1, 1'b1, 1'b1);
        total_cnt++;
        if ({done, pc_ck, clr, dev2ac, ac_ck} !== 5'b00000 || dbus !== 12'o0000)
            $display("FAIL en_low_outputs: got %b/%o want 00000/0000", {done, pc_ck, clr, dev2ac, ac_ck}, dbus);
        else pass_cnt++;
        set_ph(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_load;
        push_byte(8'h41);
        step();
        total_cnt++; if (dut.kbb_q !== 8'h41) $display("FAIL load_kbb: got %h want 41", dut.kbb_q); else pass_cnt++;
        total_cnt++; if (dut.flag_q !== 1'b1) $display("FAIL load_flag: got %0b want 1", dut.flag_q); else pass_cnt++;
        total_cnt++; if (irqRq !== 1'b0) $display("FAIL load_irq_lag: got %0b want 0", irqRq); else pass_cnt++;
        step();
        total_cnt++; if (irqRq !== 1'b1) $display("FAIL load_irq: got %0b want 1", irqRq); else pass_cnt++;
    endtask

    task automatic test_ksf;
        set_ph(1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
        total_cnt++; if ({pc_ck, done} !== 2'b00) $display("FAIL ksf1_ck1: got %b want 00", {pc_ck, done}); else pass_cnt++;
        step();
        set_ph(1'b1, 3'd1, 1'b0, 1'b1, 1'b0);
        total_cnt++; if ({pc_ck, done} !== 2'b10) $display("FAIL ksf1_stb1: got %b want 10", {pc_ck, done}); else pass_cnt++;
        step();
        set_ph(1'b1, 3'd1, 1'b0, 1'b0, 1'b1);
        total_cnt++; if ({pc_ck, done} !== 2'b01) $display("FAIL ksf1_ck2: got %b want 01", {pc_ck, done}); else pass_cnt++;
        step();
        // KCF clears the flag on ck1; irqRq follows one edge later.
        set_ph(1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
        total_cnt++; if (done !== 1'b1) $display("FAIL kcf_done: got %0b want 1", done); else pass_cnt++;
        step();
        set_ph(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        total_cnt++; if (dut.flag_q !== 1'b0) $display("FAIL kcf_flag: got %0b want 0", dut.flag_q); else pass_cnt++;
        step();
        total_cnt++; if (irqRq !== 1'b0) $display("FAIL kcf_irq_drop: got %0b want 0", irqRq); else pass_cnt++;
        set_ph(1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
        step();
        set_ph(1'b1, 3'd1, 1'b0, 1'b1, 1'b0);
        total_cnt++; if (pc_ck !== 1'b0) $display("FAIL ksf0_pc_ck: got %0b want 0", pc_ck); else pass_cnt++;
        step();
        set_ph(1'b1, 3'd1, 1'b0, 1'b0, 1'b1);
        total_cnt++; if (done !== 1'b1) $display("FAIL ksf0_done: got %0b want 1", done); else pass_cnt++;
        step();
        // Reserved code completes on ck1 and drives nothing else.
        set_ph(1'b1, 3'd7, 1'b1, 1'b0, 1'b0);
        total_cnt++; if ({done, clr, dev2ac, ac_ck} !== 4'b1000) $display("FAIL rsv7_ck1: got %b want 1000", {done, clr, dev2ac, ac_ck}); else pass_cnt++;
        step();
        set_ph(1'b1, 3'd7, 1'b0, 1'b1, 1'b0);
        total_cnt++; if ({done, ac_ck, pc_ck} !== 3'b000) $display("FAIL rsv7_stb1: got %b want 000", {done, ac_ck, pc_ck}); else pass_cnt++;
        step();
        set_ph(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_krb;
        push_byte(8'hC1);
        push_byte(8'h42);
        ac_in = 12'o7777;
        // KRS: read without clearing the flag.
        set_ph(1'b1, 3'd4, 1'b1, 1'b0, 1'b0);
        total_cnt++; if ({clr, dev2ac} !== 2'b01 || dbus !== 12'o0301) $display("FAIL krs_ck1: got %b/%o want 01/0301", {clr, dev2ac}, dbus); else pass_cnt++;
        step();
        set_ph(1'b1, 3'd4, 1'b0, 1'b1, 1'b0);
        step();
        set_ph(1'b1, 3'd4, 1'b0, 0, 1'b1);
        total_cnt++; if (dut.flag_q !== 1'b1) $display("FAIL krs_flag: got %0b want 1", dut.flag_q); else pass_cnt++;
        step();
        set_ph(1'b1, 3'd6, 1'b1, 1'b0, 1'b0);
        total_cnt++; if ({clr, dev2ac, ac_ck, done} !== 4'b1100 || dbus !== 12'o0301) $display("FAIL krb_ck1: got %b/%o want 1100/0301", {clr, dev2ac, ac_ck, done}, dbus); else pass_cnt++;
        step();
        set_ph(1'b1, 3'd6, 1'b0, 1'b1, 1'b0);
        total_cnt++; if ({clr, dev2ac, ac_ck, done} !== 4'b0110 || dbus !== 12'o0301) $display("FAIL krb_stb1: got %b/%o want 0110/0301", {clr, dev2ac, ac_ck, done}, dbus); else pass_cnt++;
        step();
        set_ph(1'b1, 3'd6, 1'b0, 1'b0, 1'b1);
        total_cnt++; if (dut.flag_q !== 1'b0 || dut.kbb_q !== 8'hC1) $display("FAIL krb_flag_clr: got %0b/%h want 0/c1", dut.flag_q, dut.kbb_q); else pass_cnt++;
        total_cnt++; if ({done, ac_ck} !== 2'b10 || dbus !== 12'o0000) $display("FAIL krb_ck2: got %b/%o want 10/0000", {done, ac_ck}, dbus); else pass_cnt++;
        step();
        set_ph(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        total_cnt++; if (dut.kbb_q !== 8'h42 || dut.flag_q !== 1'b1) $display("FAIL krb_reload: got %h/%0b want 42/1", dut.kbb_q, dut.flag_q); else pass_cnt++;
        total_cnt++; if (irqRq !== 1'b0) $display("FAIL krb_irq_drop: got %0b want 0", irqRq); else pass_cnt++;
    endtask

    task automatic test_kie;
        ac_in = 12'o0000;
        set_ph(1'b1, 3'd5, 1'b1, 1'b0, 1'b0); step();
        set_ph(1'b1, 3'd5, 1'b0, 1'b1, 1'b0); step();
        set_ph(1'b1, 3'd5, 1'b0, 1'b0, 1'b1);
        total_cnt++; if (done !== 1'b1) $display("FAIL kie_done: got %0b want 1", done); else pass_cnt++;
        step();
        set_ph(1'b1, 3'd0, 1'b1, 1'b0, 1'b0); step();
        set_ph(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        push_byte(8'h55);
        step();
        total_cnt++; if (dut.flag_q !== 1'b1 || dut.kbb_q !== 8'h55) $display("FAIL kie0_load: got %0b/%h want 1/55", dut.flag_q, dut.kbb_q); else pass_cnt++;
        step(); step();
        total_cnt++; if (irqRq !== 1'b0) $display("FAIL kie0_irq: got %0b want 0", irqRq); else pass_cnt++;
        ac_in = 12'o0001;
        set_ph(1'b1, 3'd5, 1'b1, 1'b0, 1'b0); step();
        set_ph(1'b1, 3'd5, 1'b0, 1'b1, 1'b0); step();
        total_cnt++; if (irqRq !== 1'b0) $display("FAIL kie1_irq_lag: got %0b want 0", irqRq); else pass_cnt++;
        set_ph(1'b1, 3'd5, 1'b0, 1'b0, 1'b1); step();
        set_ph(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        total_cnt++; if (irqRq !== 1'b1) $display("FAIL kie1_irq: got %0b want 1", irqRq); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        logic [11:0] d;
        run_krb(d);
        total_cnt++; if (d !== 12'h055) $display("FAIL b2b_drain: got %h want 055", d); else pass_cnt++;
        rx_valid = 1'b1;
        rx_data = 8'h10; step();
        rx_data = 8'h11; step();
        rx_data = 8'h12; step();
        total_cnt++; if (rx_ready !== 1'b0) $display("FAIL b2b_full_ready: got %0b want 0", rx_ready); else pass_cnt++;
        total_cnt++; if (dut.kbb_q !== 8'h10 || dut.u_fifo.count_q !== 2'd2) $display("FAIL b2b_fill: got %h/%0d want 10/2", dut.kbb_q, dut.u_fifo.count_q); else pass_cnt++;
        rx_data = 8'h13; step();
        rx_valid = 1'b0;
        total_cnt++; if (dut.u_fifo.count_q !== 2'd2) $display("FAIL b2b_ignore_full: got %0d want 2", dut.u_fifo.count_q); else pass_cnt++;
        run_krb(d);
        total_cnt++; if (d !== 12'h010) $display("FAIL b2b_rd0: got %h want 010", d); else pass_cnt++;
        run_krb(d);
        total_cnt++; if (d !== 12'h011) $display("FAIL b2b_rd1: got %h want 011", d); else pass_cnt++;
        run_krb(d);
        total_cnt++; if (d !== 12'h012) $display("FAIL b2b_rd2: got %h want 012", d); else pass_cnt++;
        step(); step();
        total_cnt++; if (dut.flag_q !== 1'b0 || rx_ready !== 1'b1) $display("FAIL b2b_empty: got %0b/%0b want 0/1", dut.flag_q, rx_ready); else pass_cnt++;
    endtask

    task automatic test_clear_mid_iot;
        rx_valid = 1'b1;
        rx_data = 8'h20; step();
        rx_data = 8'h21; step();
        rx_data = 8'h22; step();
        rx_valid = 1'b0;
        step();
        total_cnt++; if (irqRq !== 1'b1 || dut.u_fifo.count_q !== 2'd2) $display("FAIL clr_setup: got %0b/%0d want 1/2", irqRq, dut.u_fifo.count_q); else pass_cnt++;
        set_ph(1'b1, 3'd6, 1'b1, 1'b0, 1'b0); step();
        clear = 1'b1;
        set_ph(1'b1, 3'd6, 1'b0, 1'b1, 1'b0);
        total_cnt++; if (ac_ck !== 1'b0 || dbus !== 12'o0000) $display("FAIL clr_during: got %0b/%o want 0/0000", ac_ck, dbus); else pass_cnt++;
        step();
        clear = 1'b0;
        set_ph(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        total_cnt++; if (dut.flag_q !== 1'b0 || dut.kbb_q !== 8'h00) $display("FAIL clr_flag_kbb: got %0b/%h want 0/00", dut.flag_q, dut.kbb_q); else pass_cnt++;
        total_cnt++; if (dut.u_fifo.count_q !== 2'd0 || rx_ready !== 1'b1) $display("FAIL clr_fifo: got %0d/%0b want 0/1", dut.u_fifo.count_q, rx_ready); else pass_cnt++;
        total_cnt++; if (dut.ie_q !== 1'b1 || irqRq !== 1'b0 || ac_ck !== 1'b0) $display("FAIL clr_ie_irq: got %0b/%0b/%0b want 1/0/0", dut.ie_q, irqRq, ac_ck); else pass_cnt++;
        step(); step();
        total_cnt++; if (dut.flag_q !== 1'b0) $display("FAIL clr_no_load: got %0b want 0", dut.flag_q); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_load();
        test_ksf();
        test_krb();
        test_kie();
        test_back_to_back();
        test_clear_mid_iot();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/kbd_iot_device.md
Name: kbd_iot_device

Overview:
- Console keyboard input device, device code 03: a KL8E-style responder to the 603x IOT group.
- The CPU's IOT sequencer drives EN/IR plus the ck/stb phase pulses; this block answers with done, skip (pc_ck), AC load/clear and data strobes.
- Accepted characters are buffered, and the block raises irqRq toward the CPU interrupt logic when a character is ready and interrupts are enabled.
- A host-side valid/ready byte stream (UART receiver or testbench) feeds a small FIFO ahead of the keyboard buffer register.

Parameters:
- DEPTH, 2, entries in the input FIFO, power of 2, minimum 2.
- IE_RESET, 1, value of the interrupt-enable flag after clear.

Ports:
- CLK  in  1  system clock, all state on rising edge.
- clear  in  1  synchronous, active-high reset.
- EN  in  1  high while the current IOT addresses device 03.
- IR  in  3  IOT function bits (instruction bits 9-11).
- ck1, ck2  in  1  sequencer phase pulses, one cycle each.
- stb1  in  1  sequencer strobe pulse; follows ck1 and precedes ck2.
- ac_in  in  12  current AC value.
- done  out  1  IOT complete; the sequencer ends the instruction.
- pc_ck  out  1  skip strobe; PC increments.
- clr  out  1  clear AC before load.
- dev2ac  out  1  OR dbus into AC on the next ac_ck.
- ac_ck  out  1  AC load strobe.
- dbus  out  12  {4'b0, kbb}; valid whenever dev2ac=1, otherwise 0.
- irqRq  out  1  registered interrupt request, flag & ie.
- rx_data  in  8  host character.
- rx_valid  in  1  host character valid.
- rx_ready  out  1  FIFO not full.

Behaviour:
- Registers: kbb[7:0] buffer, flag, ie, FIFO (wr/rd pointers plus count), irqRq.
- Reset values on clear: kbb=0, flag=0, ie=IE_RESET, FIFO empty, irqRq=0, rx_ready=1.
- Combinational outputs (done, pc_ck, clr, dev2ac, ac_ck) are 0 whenever EN=0.
- clear has priority over every other event in the same cycle, including a mid-IOT reset. Any partially executed IOT is abandoned: no flag or ie update occurs.

Host side:
- A byte is accepted on a cycle with rx_valid & rx_ready.
- rx_ready = (count != DEPTH).
- Accept while full is impossible; any rx_data presented while full is ignored.

Buffer load:
- When flag=0, the FIFO is non-empty and no flag-clearing strobe is active this cycle, the FIFO head pops into kbb and flag is set on the same edge.
- If a flag clear and a load condition coincide, the clear wins and the load occurs on the next cycle.
- Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.

IOT decode (inst = EN & IR==n):
- 0 KCF: flag<=0 on ck1; done=ck1.
- 1 KSF: pc_ck=stb1 & flag; done=ck2.
- 2 KCC: clr=ck1; ac_ck=stb1; flag<=0 on stb1; done=ck2.
- 3, 7 reserved: done=ck1, no side effects.
- 4 KRS: dev2ac=ck1 and stb1; ac_ck=stb1; flag unchanged; done=ck2.
- 5 KIE: ie<=ac_in[0] on stb1; done=ck2.
- 6 KRB: clr=ck1; dev2ac=ck1 and stb1; ac_ck=stb1; flag<=0 on stb1; done=ck2. AC becomes {4'b0, kbb}.

Interrupt request:
- irqRq <= flag & ie, registered, so it lags flag by one cycle.
- After a flag clear, irqRq drops on the following edge, before the next instruction fetch.

Decomposition:
- Shared IOT package: device-code constant (6'o03), function-code localparams KCF..KRB, and the sequencer phase-pulse convention. Other IOT devices reuse the package.
- One sub-module is natural: sync_fifo (DATA_W=8, DEPTH) with push/pop/full/empty/count. The IOT decode and flag logic stay in kbd_iot_device.

Test Plan:
- Reset then push 8'h41 → within 2 cycles kbb=8'h41, flag=1; next cycle irqRq=1 (ie=1).
- KSF with flag=1 → pc_ck pulses on stb1 and done on ck2. KSF with flag=0 → pc_ck stays 0 and done still pulses.
- KRB with kbb=8'hC1 and AC=12'o7777 → clr on ck1, ac_ck on stb1, dbus=12'o0301, flag=0. With a second byte 8'h42 queued, kbb=8'h42 and flag=1 two cycles later.
- KIE with ac_in=12'o0000 then push a byte → flag=1, irqRq stays 0. KIE with ac_in=12'o0001 → irqRq=1 the next cycle.
- Push 3 bytes back-to-back with DEPTH=2 and no KRB → rx_ready=0 after the third accept (one byte in kbb, two in the FIFO). Successive KRBs return bytes in order with no loss.
- Assert clear at stb1 of a KRB with FIFO count 2 → flag=0, FIFO empty, ie=1 next cycle, no ac_ck after clear, irqRq=0.
